// File: rtl/memory_responder.sv
// Memory-side responder: word RAM plus MMIO console FIFO, cycle counter and halt.
// Reads are combinational; RAM, FIFO and registers update on the rising edge.
module memory_responder #(
   parameter int MEM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8,
   parameter     INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted,
   output logic [31:0] halt_code
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

   logic [31:0]   mem [MEM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          halted_q, halted_d;
   logic [31:0]   code_q, code_d;

   logic          ram_sel, mmio_sel;
   logic [1:0]    reg_sel;
   logic [AW-1:0] ram_idx;
   logic          ram_we, con_we, stat_we, halt_we;
   logic          full, empty, push, pop;
   logic          unused_addr;

   assign ram_sel  = (address[31:AW+2] == '0);
   assign mmio_sel = (address[31:4] == 28'h8000000);
   assign reg_sel  = address[3:2];
   assign ram_idx  = address[AW+1:2];
   assign unused_addr = ^address[1:0];

   assign ram_we  = we && ram_sel;
   assign con_we  = we && mmio_sel && (reg_sel == 2'd0);
   assign stat_we = we && mmio_sel && (reg_sel == 2'd1);
   assign halt_we = we && mmio_sel && (reg_sel == 2'd3);

   assign empty    = (cnt_q == 5'd0);
   assign full     = (cnt_q == DEPTH5);
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? fifo_q[rd_q] : 8'h00;
   assign pop      = tx_valid && tx_ready;
   // A full FIFO still takes a byte if the head leaves this cycle.
   assign push     = con_we && (!full || pop);

   assign halted    = halted_q;
   assign halt_code = code_q;

   always_comb begin
      rd_d     = rd_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      cyc_d    = cyc_q;
      halted_d = halted_q;
      code_d   = code_q;
      if (pop)
         rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      if (push)
         wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 5'd1;
         2'b01:   cnt_d = cnt_q - 5'd1;
         default: cnt_d = cnt_q;
      endcase
      if (con_we && full && !pop)
         ovf_d = 1'b1;
      if (stat_we)
         ovf_d = 1'b0;
      if (!halted_q)
         cyc_d = cyc_q + 32'd1;
      if (halt_we && !halted_q) begin
         halted_d = 1'b1;
         code_d   = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         cyc_q    <= '0;
         halted_q <= 1'b0;
         code_q   <= '0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         cyc_q    <= cyc_d;
         halted_q <= halted_d;
         code_q   <= code_d;
      end
   end

   // Storage arrays are never cleared; reset only blocks writes.
   always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
         if (ram_we)
            mem[ram_idx] <= wdata;
         if (push)
            fifo_q[wr_q] <= wdata[7:0];
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (ram_sel) begin
         rdata = mem[ram_idx];
      end else if (mmio_sel) begin
         unique case (reg_sel)
            2'd1:    rdata = {15'b0, ovf_q, 6'b0, empty, full, 3'b0, cnt_q};
            2'd2:    rdata = cyc_q;
            2'd3:    rdata = {31'b0, halted_q};
            default: rdata = 32'h0;
         endcase
      end
   end

endmodule
